// File: rtl/pixel_freq_bank.sv
// Multi-channel light-to-frequency generator: one shared shift-add multiplier scans the
// channels round-robin to compute half-period targets; each channel adopts its target at a toggle.
module pixel_freq_bank #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned LOW_FREQ   = 1_000,
    parameter int unsigned HIGH_FREQ  = 20_000_000,
    parameter int unsigned INPUT_BITS = 8,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned SEL_BITS   = 2
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [CHANNELS*INPUT_BITS-1:0] LIGHT,
    input  logic [CHANNELS-1:0]            EN,
    input  logic [SEL_BITS-1:0]            SEL,
    output logic [CHANNELS-1:0]            FREQ_OUT,
    output logic                           SEL_OUT,
    output logic                           SCAN_DONE
);

    localparam int unsigned MAX     = CLOCK_FREQ / LOW_FREQ;
    localparam int unsigned MIN_RAW = (CLOCK_FREQ + HIGH_FREQ - 1) / HIGH_FREQ;
    localparam int unsigned MIN     = (MIN_RAW < 1) ? 1 : MIN_RAW;
    localparam int unsigned STEP    = (MAX - MIN) >> INPUT_BITS;
    localparam int unsigned CW      = $clog2(MAX + 1);
    localparam int unsigned PW      = CW + INPUT_BITS;
    localparam int unsigned IW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned MW      = (INPUT_BITS > 1) ? $clog2(INPUT_BITS) : 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MUL   = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [MW-1:0]         mcnt;
    logic [INPUT_BITS-1:0] lreg;
    logic [PW-1:0]         acc;
    logic [CW-1:0]         target [CHANNELS];
    logic [CW-1:0]         active [CHANNELS];
    logic [CW-1:0]         cnt    [CHANNELS];

    logic [INPUT_BITS-1:0] light_c;
    logic                  sel_c;
    logic [CW-1:0]         new_target_c;

    // Light of the channel being loaded, selected channel output, and clamped target
    always_comb begin
        light_c = '0;
        sel_c   = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (idx == IW'(c)) light_c = LIGHT[c*INPUT_BITS +: INPUT_BITS];
            if (SEL == SEL_BITS'(c)) sel_c = FREQ_OUT[c];
        end
        new_target_c = (acc > PW'(MAX - MIN)) ? CW'(MIN) : CW'(PW'(MAX) - acc);
    end

    // Sequencer: LOAD latches the light, MUL does MSB-first shift-add, STORE writes the target
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= LOAD;
            idx       <= '0;
            mcnt      <= '0;
            lreg      <= '0;
            acc       <= '0;
            SCAN_DONE <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) target[c] <= CW'(MAX);
        end else begin
            SCAN_DONE <= 1'b0;
            case (state)
                LOAD: begin
                    lreg  <= light_c;
                    acc   <= '0;
                    mcnt  <= '0;
                    state <= MUL;
                end
                MUL: begin
                    acc  <= (acc << 1) + (lreg[INPUT_BITS-1] ? PW'(STEP) : PW'(0));
                    lreg <= lreg << 1;
                    mcnt <= mcnt + MW'(1);
                    if (mcnt == MW'(INPUT_BITS - 1)) state <= STORE;
                end
                STORE: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (idx == IW'(c)) target[c] <= new_target_c;
                    end
                    SCAN_DONE <= (idx == IW'(CHANNELS - 1));
                    idx       <= (idx == IW'(CHANNELS - 1)) ? IW'(0) : idx + IW'(1);
                    state     <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Per-channel half-period counters; the period only changes at a toggle or while disabled
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            FREQ_OUT <= '0;
            SEL_OUT  <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt[c]    <= '0;
                active[c] <= CW'(MAX);
            end
        end else begin
            SEL_OUT <= sel_c;
            for (int c = 0; c < CHANNELS; c++) begin
                if (EN[c]) begin
                    if (cnt[c] == active[c] - CW'(1)) begin
                        FREQ_OUT[c] <= ~FREQ_OUT[c];
                        cnt[c]      <= '0;
                        active[c]   <= target[c];
                    end else begin
                        cnt[c] <= cnt[c] + CW'(1);
                    end
                end else begin
                    FREQ_OUT[c] <= 1'b0;
                    cnt[c]      <= '0;
                    active[c]   <= target[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_freq_bank.sv
// Bench for pixel_freq_bank: cycle-level reference model feeding a scoreboard, plus
// directed half-period and scan-timing measurements.
module tb_pixel_freq_bank;

    localparam int CF    = 1000;
    localparam int LF    = 10;
    localparam int HF    = 500;
    localparam int IB    = 4;
    localparam int NCH   = 3;
    localparam int SB    = 2;
    localparam int MAXV  = CF / LF;
    localparam int MINV  = (CF + HF - 1) / HF;
    localparam int STEPV = (MAXV - MINV) / (1 << IB);
    localparam int CHCYC = IB + 2;
    localparam int SCANV = NCH * CHCYC;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*IB-1:0] light;
    logic [NCH-1:0]    en;
    logic [SB-1:0]     sel;
    logic [NCH-1:0]    freq_out;
    logic              sel_out;
    logic              scan_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [NCH+1:0] sb_q[$];

    pixel_freq_bank #(
        .CLOCK_FREQ(CF), .LOW_FREQ(LF), .HIGH_FREQ(HF),
        .INPUT_BITS(IB), .CHANNELS(NCH), .SEL_BITS(SB)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .LIGHT(light), .EN(en), .SEL(sel),
        .FREQ_OUT(freq_out), .SEL_OUT(sel_out), .SCAN_DONE(scan_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // Reference model: scan schedule and half-period lengths from plain arithmetic
    task automatic model_proc();
        int tgt[NCH];
        int act[NCH];
        int el[NCH];
        int snap = 0;
        int t = 0;
        int ch, sub, s, v;
        logic [NCH-1:0] out = '0;
        logic [NCH-1:0] prev;
        logic msel = 1'b0;
        logic mdone = 1'b0;
        forever begin
            @(posedge clk);
            prev = out;
            if (!rst_n) begin
                t = 0;
                out = '0;
                msel = 1'b0;
                mdone = 1'b0;
                for (int c = 0; c < NCH; c++) begin
                    tgt[c] = MAXV;
                    act[c] = MAXV;
                    el[c] = 0;
                end
            end else begin
                s = int'(sel);
                msel = (s < NCH) ? prev[s] : 1'b0;
                for (int c = 0; c < NCH; c++) begin
                    if (en[c]) begin
                        el[c]++;
                        if (el[c] == act[c]) begin
                            out[c] = ~out[c];
                            el[c] = 0;
                            act[c] = tgt[c];
                        end
                    end else begin
                        el[c] = 0;
                        out[c] = 1'b0;
                        act[c] = tgt[c];
                    end
                end
                ch = (t % SCANV) / CHCYC;
                sub = (t % SCANV) % CHCYC;
                mdone = 1'b0;
                if (sub == 0) snap = int'(light[ch*IB +: IB]);
                if (sub == CHCYC - 1) begin
                    v = MAXV - STEPV * snap;
                    tgt[ch] = (v < MINV) ? MINV : v;
                    mdone = (ch == NCH - 1);
                end
                t++;
            end
            sb_q.push_back({out, msel, mdone});
        end
    endtask

    // Monitor: compares every presented output vector against the model's prediction
    task automatic monitor_proc();
        logic [NCH+1:0] exp, got;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                got = {freq_out, sel_out, scan_done};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL scoreboard @%0t: got out=%b sel=%b done=%b, expected out=%b sel=%b done=%b",
                             $time, got[NCH+1:2], got[1], got[0], exp[NCH+1:2], exp[1], exp[0]);
                end
            end
        end
    endtask

    task automatic cycles_to_toggle(input int ch, output int n);
        logic v0;
        v0 = freq_out[ch];
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (freq_out[ch] == v0 && n < 400);
    endtask

    task automatic cycles_to_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_done && n < 100);
    endtask

    task automatic measure_half(input string name, input int ch, input int exp);
        int n;
        cycles_to_toggle(ch, n);
        cycles_to_toggle(ch, n);
        check(name, n, exp);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        light = '0;
        en    = 3'b111;
        sel   = '0;
        fork
            model_proc();
            monitor_proc();
        join_none

        // Reset and light=0 behaviour
        repeat (3) @(negedge clk);
        check("reset_freq_out", int'(freq_out), 0);
        check("reset_sel_out", int'(sel_out), 0);
        check("reset_scan_done", int'(scan_done), 0);
        rst_n = 1'b1;
        cycles_to_done(n);
        check("first_scan_done", n, 18);
        cycles_to_done(n);
        check("second_scan_done", n, 18);
        cycles_to_toggle(0, n);
        check("first_toggle_ch0", n, 64);
        cycles_to_toggle(0, n);
        check("half_light0_ch0", n, 100);

        // Distinct light levels per channel
        light = {4'd0, 4'd8, 4'd15};
        repeat (250) @(negedge clk);
        measure_half("half_light15_ch0", 0, 10);
        measure_half("half_light8_ch1", 1, 52);
        measure_half("half_light0_ch2", 2, 100);

        // Light change mid half-period must not shorten the current half
        light[7:4] = 4'd0;
        repeat (250) @(negedge clk);
        cycles_to_toggle(1, n);
        repeat (30) @(negedge clk);
        light[7:4] = 4'd15;
        cycles_to_toggle(1, n);
        check("intact_half_ch1", n, 70);
        cycles_to_toggle(1, n);
        check("new_half_ch1", n, 10);

        // Enable drop and restart on ch2
        n = 0;
        while (!freq_out[2] && n < 300) begin
            @(negedge clk);
            n++;
        end
        en[2] = 1'b0;
        @(negedge clk);
        check("en_low_clears_ch2", int'(freq_out[2]), 0);
        repeat (29) @(negedge clk);
        en[2] = 1'b1;
        cycles_to_toggle(2, n);
        check("en_rise_first_toggle_ch2", n, 100);

        // Selected-channel output
        sel = 2'd1;
        repeat (150) @(negedge clk);
        sel = 2'd3;
        repeat (5) @(negedge clk);
        check("sel_out_of_range", int'(sel_out), 0);
        repeat (50) @(negedge clk);

        // Reset during MUL of ch1
        cycles_to_done(n);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midmul_reset_freq_out", int'(freq_out), 0);
        check("midmul_reset_sel_out", int'(sel_out), 0);
        check("midmul_reset_scan_done", int'(scan_done), 0);
        rst_n = 1'b1;
        cycles_to_done(n);
        check("scan_done_after_reset", n, 18);
        cycles_to_toggle(0, n);
        check("ch0_period_reset_to_max", n, 82);

        // Randomized traffic checked by the scoreboard
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) light = NCH*IB'($urandom);
            if ($urandom_range(0, 39) == 0) en[$urandom_range(0, NCH-1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) sel = SB'($urandom);
            rst_n = ($urandom_range(0, 599) != 0);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
